// File: rtl/twohot_counter_pkg.sv
// ============================================================================
// twohot_counter_pkg : 2-hot digit code map and widths shared by the counter
//                      and the downstream 2-hot 5->4 encoder.
// Revision 1.0
// ============================================================================
`default_nettype none

package twohot_counter_pkg;

   localparam int TH_WIDTH  = 5;
   localparam int BIN_WIDTH = 4;

   typedef logic [TH_WIDTH-1:0]  th_code_t;
   typedef logic [BIN_WIDTH-1:0] th_bin_t;

   localparam th_code_t TH_D0 = 5'b00011;
   localparam th_code_t TH_D1 = 5'b00101;
   localparam th_code_t TH_D2 = 5'b00110;
   localparam th_code_t TH_D3 = 5'b01010;
   localparam th_code_t TH_D4 = 5'b01001;
   localparam th_code_t TH_D5 = 5'b01100;
   localparam th_code_t TH_D6 = 5'b10100;
   localparam th_code_t TH_D7 = 5'b10010;
   localparam th_code_t TH_D8 = 5'b10001;
   localparam th_code_t TH_D9 = 5'b11000;

endpackage

`default_nettype wire

// File: rtl/twohot_enc_4_5.sv
// ============================================================================
// twohot_enc_4_5 : binary digit -> 2-hot code; values above 9 give code(0)
//                  and raise oor.
// Revision 1.0
// ============================================================================
`default_nettype none

module twohot_enc_4_5
   import twohot_counter_pkg::*;
(
   input  logic [BIN_WIDTH-1:0] bin,
   output logic [TH_WIDTH-1:0]  code,
   output logic                 oor
);

   always_comb begin
      code = TH_D0;
      oor  = 1'b0;
      case (bin)
         4'd0:    code = TH_D0;
         4'd1:    code = TH_D1;
         4'd2:    code = TH_D2;
         4'd3:    code = TH_D3;
         4'd4:    code = TH_D4;
         4'd5:    code = TH_D5;
         4'd6:    code = TH_D6;
         4'd7:    code = TH_D7;
         4'd8:    code = TH_D8;
         4'd9:    code = TH_D9;
         default: oor  = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/twohot_counter.sv
// ============================================================================
// twohot_counter : mod-10 up/down counter holding its digit in 2-hot form,
//                  with parallel load, cascade tc and illegal-state recovery.
// Revision 1.0
// ============================================================================
`default_nettype none

module twohot_counter
   import twohot_counter_pkg::*;
#(
   parameter int RESET_VAL = 0
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 up,
   input  logic                 load,
   input  logic [BIN_WIDTH-1:0] load_val,
   output logic [TH_WIDTH-1:0]  out,
   output logic                 tc,
   output logic                 err
);

   // Out-of-range RESET_VAL is steered to an illegal binary so the encoder yields code(0).
   localparam th_bin_t c_reset_bin = (RESET_VAL < 0 || RESET_VAL > 15) ? 4'hF
                                                                       : th_bin_t'(RESET_VAL);

   th_code_t out_q, out_d;
   logic     err_q, err_d;
   th_code_t load_code, reset_code_raw, reset_code;
   logic     load_oor, reset_oor;
   th_code_t succ_code, pred_code;
   logic     legal;

   twohot_enc_4_5 u_enc_load (
      .bin  (load_val),
      .code (load_code),
      .oor  (load_oor)
   );

   twohot_enc_4_5 u_enc_reset (
      .bin  (c_reset_bin),
      .code (reset_code_raw),
      .oor  (reset_oor)
   );

   assign reset_code = reset_oor ? TH_D0 : reset_code_raw;

   always_comb begin
      legal     = 1'b1;
      succ_code = TH_D0;
      pred_code = TH_D0;
      case (out_q)
         TH_D0:   begin succ_code = TH_D1; pred_code = TH_D9; end
         TH_D1:   begin succ_code = TH_D2; pred_code = TH_D0; end
         TH_D2:   begin succ_code = TH_D3; pred_code = TH_D1; end
         TH_D3:   begin succ_code = TH_D4; pred_code = TH_D2; end
         TH_D4:   begin succ_code = TH_D5; pred_code = TH_D3; end
         TH_D5:   begin succ_code = TH_D6; pred_code = TH_D4; end
         TH_D6:   begin succ_code = TH_D7; pred_code = TH_D5; end
         TH_D7:   begin succ_code = TH_D8; pred_code = TH_D6; end
         TH_D8:   begin succ_code = TH_D9; pred_code = TH_D7; end
         TH_D9:   begin succ_code = TH_D0; pred_code = TH_D8; end
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      out_d = out_q;
      err_d = 1'b0;
      if (load) begin
         out_d = load_code;
         err_d = load_oor;
      end else if (!legal) begin
         // Recovery ignores en: a corrupt digit must never propagate a count.
         out_d = TH_D0;
         err_d = 1'b1;
      end else if (en) begin
         out_d = up ? succ_code : pred_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= reset_code;
         err_q <= 1'b0;
      end else begin
         out_q <= out_d;
         err_q <= err_d;
      end
   end

   always_comb begin
      tc = en & ~load & ~rst & legal &
           ((up & (out_q == TH_D9)) | (~up & (out_q == TH_D0)));
   end

   assign out = out_q;
   assign err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_twohot_counter.sv
// ============================================================================
// tb_twohot_counter : directed and randomized checks of a two-digit chain
//                     against a digit-arithmetic reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_twohot_counter;

   logic       clk = 1'b0;
   logic       rst, en, up, load;
   logic [3:0] load_val;

   logic [4:0] lo_out, hi_out, cfg_out;
   logic       lo_tc, hi_tc, cfg_tc;
   logic       lo_err, hi_err, cfg_err;

   always #5 clk = ~clk;

   twohot_counter #(.RESET_VAL(0)) dut_lo (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
      .out(lo_out), .tc(lo_tc), .err(lo_err)
   );

   twohot_counter #(.RESET_VAL(0)) dut_hi (
      .clk(clk), .rst(rst), .en(lo_tc), .up(up), .load(1'b0), .load_val(4'd0),
      .out(hi_out), .tc(hi_tc), .err(hi_err)
   );

   twohot_counter #(.RESET_VAL(12)) dut_cfg (
      .clk(clk), .rst(rst), .en(1'b0), .up(1'b1), .load(1'b0), .load_val(4'd0),
      .out(cfg_out), .tc(cfg_tc), .err(cfg_err)
   );

   logic [4:0] code_map [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01001,
                                 5'b01100, 5'b10100, 5'b10010, 5'b10001, 5'b11000};

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: plain digit values for both chained counters.
   int m_d   = 0;
   int h_d   = 0;
   bit m_err = 1'b0;
   bit m_bad = 1'b0;

   logic [4:0] bad_pat = 5'b00111;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic step(input bit rst_i, input bit load_i, input int lv,
                       input bit en_i, input bit up_i, input bit corrupt);
      bit exp_tc, exp_htc;
      rst      = rst_i;
      load     = load_i;
      load_val = 4'(lv);
      en       = en_i;
      up       = up_i;
      if (corrupt) begin
         force dut_lo.out_q = bad_pat;
         m_bad = 1'b1;
      end
      #1;
      exp_tc  = !rst_i && !load_i && !m_bad && en_i &&
                ((up_i && m_d == 9) || (!up_i && m_d == 0));
      exp_htc = exp_tc && ((up_i && h_d == 9) || (!up_i && h_d == 0));
      chk("lo_tc", lo_tc, exp_tc);
      chk("hi_tc", hi_tc, exp_htc);
      if (corrupt) begin
         chk("corrupt_out", lo_out, bad_pat);
         release dut_lo.out_q;
      end
      @(posedge clk);
      if (rst_i) begin
         m_d = 0; h_d = 0; m_err = 1'b0; m_bad = 1'b0;
      end else if (load_i) begin
         m_bad = 1'b0;
         if (lv <= 9) begin m_d = lv; m_err = 1'b0; end
         else begin m_d = 0; m_err = 1'b1; end
      end else if (m_bad) begin
         m_d = 0; m_err = 1'b1; m_bad = 1'b0;
      end else begin
         m_err = 1'b0;
         if (en_i) m_d = up_i ? (m_d + 1) % 10 : (m_d + 9) % 10;
         if (exp_tc) h_d = up_i ? (h_d + 1) % 10 : (h_d + 9) % 10;
      end
      @(negedge clk);
      chk("lo_out", lo_out, code_map[m_d]);
      chk("lo_err", lo_err, m_err);
      chk("hi_out", hi_out, code_map[h_d]);
      chk("hi_err", hi_err, 1'b0);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 4'd0;

      // Reset, then tc must stay low at digit 0 counting up.
      step(1, 0, 0, 1, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      chk("cfg_reset_out", cfg_out, 5'b00011);
      chk("cfg_reset_err", cfg_err, 1'b0);

      // Full up sweep with wrap.
      repeat (11) step(0, 0, 0, 1, 1, 0);

      // Down wrap from a loaded 0.
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("down_wrap", lo_out, 5'b11000);

      // Illegal load value.
      step(0, 1, 12, 0, 1, 0);
      chk("illegal_load_err", lo_err, 1'b1);
      step(0, 0, 0, 0, 1, 0);

      // Corrupt state recovery (tc must stay low even with en high).
      bad_pat = 5'b00111;
      step(0, 0, 0, 1, 1, 1);
      chk("corrupt_recover", lo_out, 5'b00011);
      step(0, 0, 0, 0, 1, 0);

      // Load beats en, then cascade into the high digit exactly once.
      step(1, 0, 0, 0, 1, 0);
      step(0, 1, 7, 1, 1, 0);
      chk("load_priority", lo_out, 5'b10010);
      repeat (3) step(0, 0, 0, 1, 1, 0);
      chk("cascade_lo", lo_out, 5'b00011);
      chk("cascade_hi", hi_out, 5'b00101);

      // Randomized traffic.
      repeat (400) begin
         bit r_rst, r_ld, r_en, r_up, r_cor;
         int r_lv;
         r_rst = ($urandom_range(0, 99) < 3);
         r_ld  = ($urandom_range(0, 99) < 15);
         r_lv  = int'($urandom_range(0, 15));
         r_en  = ($urandom_range(0, 99) < 70);
         r_up  = 1'($urandom_range(0, 1));
         r_cor = ($urandom_range(0, 99) < 5);
         if (r_cor) begin
            bad_pat = 5'($urandom_range(0, 31));
            while ($countones(bad_pat) == 2) bad_pat = 5'($urandom_range(0, 31));
         end
         step(r_rst, r_ld, r_lv, r_en, r_up, r_cor);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
